sdram_port_arbiter: RTL and testbench

- Shares the single write port and single read port of the SDRAM controller between four clients: two writers (W0, W1) and two readers (R0, R1), e.g. camera-in and LCD-out FIFOs.
- Presents exactly one outstanding request to the controller at a time, chosen by round-robin.
- Routes the controller ack and data to the granted client only.
- Sits between the frame-buffer FIFOs and the SDRAM controller.

---
 rtl/sdram_arb_pkg.sv | 37 +++
 rtl/rr_pick4.sv | 28 ++
 rtl/sdram_port_arbiter.sv | 216 +++++++++++++++++++++
 tb/tb_sdram_port_arbiter.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_arb_pkg.sv
// Shared definitions for the SDRAM port arbiter: FSM encoding, client
// indices (grant bit positions) and small grant-vector helpers.
package sdram_arb_pkg;

    localparam logic [2:0] ST_INIT = 3'd0;
    localparam logic [2:0] ST_IDLE = 3'd1;
    localparam logic [2:0] ST_REQ  = 3'd2;
    localparam logic [2:0] ST_XFER = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;

    // Client index doubles as the bit position in the one-hot grant and
    // as the round-robin scan order W0, R0, W1, R1.
    localparam logic [1:0] IDX_W0 = 2'd0;
    localparam logic [1:0] IDX_R0 = 2'd1;
    localparam logic [1:0] IDX_W1 = 2'd2;
    localparam logic [1:0] IDX_R1 = 2'd3;

    // Encode a one-hot grant into a client index (0 for an empty vector).
    function automatic logic [1:0] onehot_to_idx(input logic [3:0] oh);
        logic [1:0] idx;
        idx = 2'd0;
        case (oh)
            4'b0001: idx = IDX_W0;
            4'b0010: idx = IDX_R0;
            4'b0100: idx = IDX_W1;
            4'b1000: idx = IDX_R1;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

    // True when the grant selects one of the two writers.
    function automatic logic is_writer(input logic [3:0] oh);
        return oh[IDX_W0] | oh[IDX_W1];
    endfunction

endpackage

// File: rtl/rr_pick4.sv
// Four-way round-robin picker: returns the first requesting client at or
// after the pointer, wrapping around, as a one-hot vector.
module rr_pick4 (
    input  logic [3:0] req,
    input  logic [1:0] ptr,
    output logic [3:0] gnt,
    output logic       valid
);

    logic [1:0] idx_s;

    // Scan from the pointer; the first set request wins.
    always_comb begin
        gnt   = 4'b0000;
        valid = 1'b0;
        idx_s = ptr;
        for (int off = 0; off < 4; off++) begin
            idx_s = ptr + off[1:0];
            if (!valid && req[idx_s]) begin
                gnt[idx_s] = 1'b1;
                valid      = 1'b1;
            end else begin
                valid = valid;
            end
        end
    end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Shares the SDRAM controller's write and read ports between two writers
// and two readers, one outstanding request at a time, round-robin order.
module sdram_port_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int ADDR_W  = 24,
    parameter int BURST_W = 10,
    parameter int DATA_W  = 64,
    parameter int TIMEOUT = 1023
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               init_done,
    input  logic [1:0]         wr_req,
    input  logic [ADDR_W-1:0]  wr_addr  [0:1],
    input  logic [BURST_W-1:0] wr_burst [0:1],
    input  logic [DATA_W-1:0]  wr_din   [0:1],
    output logic [1:0]         wr_ack,
    input  logic [1:0]         rd_req,
    input  logic [ADDR_W-1:0]  rd_addr  [0:1],
    input  logic [BURST_W-1:0] rd_burst [0:1],
    output logic [1:0]         rd_ack,
    output logic [DATA_W-1:0]  rd_dout,
    output logic               sdram_wr_req,
    input  logic               sdram_wr_ack,
    output logic [ADDR_W-1:0]  sdram_wr_addr,
    output logic [BURST_W-1:0] sdram_wr_burst,
    output logic [DATA_W-1:0]  sdram_din,
    output logic               sdram_rd_req,
    input  logic               sdram_rd_ack,
    output logic [ADDR_W-1:0]  sdram_rd_addr,
    output logic [BURST_W-1:0] sdram_rd_burst,
    input  logic [DATA_W-1:0]  sdram_dout,
    output logic [3:0]         grant,
    output logic               err_timeout
);

    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TIMEOUT_M1 = CNT_W'(TIMEOUT - 1);

    logic [2:0]         state_r;
    logic [3:0]         grant_r;
    logic [1:0]         ptr_r;
    logic [CNT_W-1:0]   cnt_r;
    logic               err_r;
    logic               wr_req_r;
    logic               rd_req_r;
    logic [ADDR_W-1:0]  addr_r;
    logic [BURST_W-1:0] burst_r;

    logic [3:0]         elig_s;
    logic [3:0]         pick_gnt_s;
    logic               pick_valid_s;
    logic [ADDR_W-1:0]  pick_addr_s;
    logic [BURST_W-1:0] pick_burst_s;
    logic [1:0]         grant_idx_s;
    logic               ack_s;

    // A zero-length burst never becomes eligible, so it is never granted.
    always_comb begin
        elig_s         = 4'b0000;
        elig_s[IDX_W0] = wr_req[0] & (wr_burst[0] != {BURST_W{1'b0}});
        elig_s[IDX_R0] = rd_req[0] & (rd_burst[0] != {BURST_W{1'b0}});
        elig_s[IDX_W1] = wr_req[1] & (wr_burst[1] != {BURST_W{1'b0}});
        elig_s[IDX_R1] = rd_req[1] & (rd_burst[1] != {BURST_W{1'b0}});
    end

    rr_pick4 u_pick (
        .req   (elig_s),
        .ptr   (ptr_r),
        .gnt   (pick_gnt_s),
        .valid (pick_valid_s)
    );

    // Select address and burst length of the client the picker chose.
    always_comb begin
        pick_addr_s  = {ADDR_W{1'b0}};
        pick_burst_s = {BURST_W{1'b0}};
        case (onehot_to_idx(pick_gnt_s))
            IDX_W0: begin
                pick_addr_s  = wr_addr[0];
                pick_burst_s = wr_burst[0];
            end
            IDX_R0: begin
                pick_addr_s  = rd_addr[0];
                pick_burst_s = rd_burst[0];
            end
            IDX_W1: begin
                pick_addr_s  = wr_addr[1];
                pick_burst_s = wr_burst[1];
            end
            IDX_R1: begin
                pick_addr_s  = rd_addr[1];
                pick_burst_s = rd_burst[1];
            end
            default: begin
                pick_addr_s  = {ADDR_W{1'b0}};
                pick_burst_s = {BURST_W{1'b0}};
            end
        endcase
    end

    // Controller ack belonging to the direction currently granted.
    always_comb begin
        grant_idx_s = onehot_to_idx(grant_r);
        if (is_writer(grant_r)) begin
            ack_s = sdram_wr_ack;
        end else begin
            ack_s = sdram_rd_ack;
        end
    end

    // Arbitration FSM: grant, hold the controller request, track the
    // transfer, then advance the round-robin pointer past the served client.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r  <= ST_INIT;
            grant_r  <= 4'b0000;
            ptr_r    <= IDX_W0;
            cnt_r    <= {CNT_W{1'b0}};
            err_r    <= 1'b0;
            wr_req_r <= 1'b0;
            rd_req_r <= 1'b0;
            addr_r   <= {ADDR_W{1'b0}};
            burst_r  <= {BURST_W{1'b0}};
        end else begin
            case (state_r)
                ST_INIT: begin
                    if (init_done) begin
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= ST_INIT;
                    end
                end
                ST_IDLE: begin
                    if (!init_done) begin
                        state_r <= ST_INIT;
                    end else if (pick_valid_s) begin
                        grant_r  <= pick_gnt_s;
                        addr_r   <= pick_addr_s;
                        burst_r  <= pick_burst_s;
                        cnt_r    <= {CNT_W{1'b0}};
                        wr_req_r <= is_writer(pick_gnt_s);
                        rd_req_r <= ~is_writer(pick_gnt_s);
                        state_r  <= ST_REQ;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_REQ: begin
                    if (ack_s) begin
                        wr_req_r <= 1'b0;
                        rd_req_r <= 1'b0;
                        state_r  <= ST_XFER;
                    end else if (cnt_r == TIMEOUT_M1) begin
                        // Controller never answered: abort and flag it.
                        wr_req_r <= 1'b0;
                        rd_req_r <= 1'b0;
                        err_r    <= 1'b1;
                        state_r  <= ST_DONE;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                ST_XFER: begin
                    if (!ack_s) begin
                        state_r <= ST_DONE;
                    end else begin
                        state_r <= ST_XFER;
                    end
                end
                ST_DONE: begin
                    grant_r <= 4'b0000;
                    ptr_r   <= grant_idx_s + 2'd1;
                    if (init_done) begin
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= ST_INIT;
                    end
                end
                default: begin
                    state_r  <= ST_INIT;
                    grant_r  <= 4'b0000;
                    wr_req_r <= 1'b0;
                    rd_req_r <= 1'b0;
                end
            endcase
        end
    end

    // Ack routing and write-data steering follow the registered grant.
    always_comb begin
        wr_ack[0] = sdram_wr_ack & grant_r[IDX_W0];
        wr_ack[1] = sdram_wr_ack & grant_r[IDX_W1];
        rd_ack[0] = sdram_rd_ack & grant_r[IDX_R0];
        rd_ack[1] = sdram_rd_ack & grant_r[IDX_R1];
        if (grant_r[IDX_W0]) begin
            sdram_din = wr_din[0];
        end else if (grant_r[IDX_W1]) begin
            sdram_din = wr_din[1];
        end else begin
            sdram_din = {DATA_W{1'b0}};
        end
    end

    assign rd_dout        = sdram_dout;
    assign sdram_wr_req   = wr_req_r;
    assign sdram_rd_req   = rd_req_r;
    assign sdram_wr_addr  = addr_r;
    assign sdram_rd_addr  = addr_r;
    assign sdram_wr_burst = burst_r;
    assign sdram_rd_burst = burst_r;
    assign grant          = grant_r;
    assign err_timeout    = err_r;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Scoreboard bench for sdram_port_arbiter: stimulus pushes the expected
// grant sequence, a negedge monitor pops and checks each grant window.
module tb_sdram_port_arbiter;
    import sdram_arb_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n, init_done;
    logic [1:0]  wr_req, rd_req, wr_ack, rd_ack;
    logic [23:0] wr_addr [0:1];
    logic [9:0]  wr_burst [0:1];
    logic [63:0] wr_din [0:1];
    logic [23:0] rd_addr [0:1];
    logic [9:0]  rd_burst [0:1];
    logic [63:0] rd_dout, sdram_din, sdram_dout;
    logic        sdram_wr_req, sdram_wr_ack, sdram_rd_req, sdram_rd_ack;
    logic [23:0] sdram_wr_addr, sdram_rd_addr;
    logic [9:0]  sdram_wr_burst, sdram_rd_burst;
    logic [3:0]  grant;
    logic        err_timeout;

    always #5 clk = ~clk;

    sdram_port_arbiter #(.ADDR_W(24), .BURST_W(10), .DATA_W(64), .TIMEOUT(15)) dut (
        .clk(clk), .rst_n(rst_n), .init_done(init_done),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_burst(wr_burst), .wr_din(wr_din),
        .wr_ack(wr_ack), .rd_req(rd_req), .rd_addr(rd_addr), .rd_burst(rd_burst),
        .rd_ack(rd_ack), .rd_dout(rd_dout),
        .sdram_wr_req(sdram_wr_req), .sdram_wr_ack(sdram_wr_ack),
        .sdram_wr_addr(sdram_wr_addr), .sdram_wr_burst(sdram_wr_burst),
        .sdram_din(sdram_din), .sdram_rd_req(sdram_rd_req),
        .sdram_rd_ack(sdram_rd_ack), .sdram_rd_addr(sdram_rd_addr),
        .sdram_rd_burst(sdram_rd_burst), .sdram_dout(sdram_dout),
        .grant(grant), .err_timeout(err_timeout)
    );

    typedef struct {
        logic [3:0]  grant;
        logic [23:0] addr;
        logic [63:0] din;
        int          acks;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        mon_cur;
    logic        mon_in_win = 1'b0;
    int          mon_acks, mon_dout_err;
    int          stray_cnt = 0;
    int          checks = 0;
    int          failures = 0;
    logic        ctl_en = 1'b0;
    logic [63:0] ctl_data = 64'd0;
    logic        m_is_w;
    int          m_n;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [3:0] g, input logic [23:0] a, input logic [63:0] d, input int n);
        exp_t e;
        e.grant = g; e.addr = a; e.din = d; e.acks = n;
        sb_q.push_back(e);
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        chk({name, "_drain"}, 64'(sb_q.size()), 64'd0);
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n, quiet;
        n = 0; quiet = 0;
        while (quiet < 4 && n < budget) begin
            @(posedge clk); #1;
            n++;
            if (grant == 4'b0000 && !mon_in_win) quiet++;
            else quiet = 0;
        end
        chk({name, "_idle"}, 64'(quiet >= 4), 64'd1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    // Controller model: after a request, 2 cycles latency then burst acks.
    initial begin
        sdram_wr_ack = 1'b0; sdram_rd_ack = 1'b0; sdram_dout = 64'd0;
        forever begin
            @(posedge clk); #1;
            if (ctl_en && rst_n && (sdram_wr_req || sdram_rd_req)) begin
                m_is_w = sdram_wr_req;
                m_n    = m_is_w ? int'(sdram_wr_burst) : int'(sdram_rd_burst);
                repeat (2) @(posedge clk);
                #1;
                for (int k = 0; k < m_n; k++) begin
                    if (!rst_n) break;
                    ctl_data   = 64'hD000_0000_0000_0000 + 64'(sdram_rd_addr) + 64'(k);
                    sdram_dout = ctl_data;
                    if (m_is_w) sdram_wr_ack = 1'b1;
                    else        sdram_rd_ack = 1'b1;
                    @(posedge clk); #1;
                end
                sdram_wr_ack = 1'b0;
                sdram_rd_ack = 1'b0;
            end
        end
    end

    // Monitor: open a window on each grant, check it, count acks until it closes.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                mon_in_win = 1'b0;
            end else begin
                for (int i = 0; i < 2; i++) begin
                    if (wr_ack[i] && !grant[2*i])   stray_cnt++;
                    if (rd_ack[i] && !grant[2*i+1]) stray_cnt++;
                end
                if (!mon_in_win && grant != 4'b0000) begin
                    if (sb_q.size() == 0) begin
                        chk("unexpected_grant", 64'(grant), 64'd0);
                    end else begin
                        mon_cur = sb_q.pop_front();
                        chk("grant_order", 64'(grant), 64'(mon_cur.grant));
                        if (grant[0] | grant[2]) chk("wr_addr", 64'(sdram_wr_addr), 64'(mon_cur.addr));
                        else                     chk("rd_addr", 64'(sdram_rd_addr), 64'(mon_cur.addr));
                        chk("sdram_din", sdram_din, mon_cur.din);
                        mon_in_win = 1'b1; mon_acks = 0; mon_dout_err = 0;
                    end
                end else if (mon_in_win) begin
                    if (grant == 4'b0000) begin
                        chk("ack_count", 64'(mon_acks), 64'(mon_cur.acks));
                        chk("rd_dout", 64'(mon_dout_err), 64'd0);
                        mon_in_win = 1'b0;
                    end else begin
                        if (wr_ack != 2'b00 || rd_ack != 2'b00) mon_acks++;
                        if (rd_ack != 2'b00 && rd_dout !== ctl_data) mon_dout_err++;
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   cnt;
        logic seen;
        rst_n = 1'b0; init_done = 1'b0; wr_req = 2'b00; rd_req = 2'b00;
        for (int i = 0; i < 2; i++) begin
            wr_addr[i] = 24'd0; wr_burst[i] = 10'd0; wr_din[i] = 64'd0;
            rd_addr[i] = 24'd0; rd_burst[i] = 10'd0;
        end
        ctl_en = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_grant", 64'(grant), 64'd0);
        chk("rst_wr_req", 64'(sdram_wr_req), 64'd0);
        chk("rst_rd_req", 64'(sdram_rd_req), 64'd0);
        chk("rst_err", 64'(err_timeout), 64'd0);
        chk("rst_addr", 64'(sdram_wr_addr), 64'd0);

        // T1: no grant before init_done, then request two cycles after it rises.
        rst_n = 1'b1;
        wr_addr[0] = 24'h123456; wr_burst[0] = 10'd8; wr_din[0] = 64'hAAAA_0000_0000_0001;
        wr_req[0] = 1'b1;
        push(4'b0001, 24'h123456, 64'hAAAA_0000_0000_0001, 8);
        seen = 1'b0;
        repeat (50) begin
            @(posedge clk); #1;
            if (sdram_wr_req || grant != 4'b0000) seen = 1'b1;
        end
        chk("init_hold", 64'(seen), 64'd0);
        init_done = 1'b1;
        @(posedge clk); #1;
        chk("init_lat1", 64'(sdram_wr_req), 64'd0);
        @(posedge clk); #1;
        chk("init_lat2", 64'(sdram_wr_req), 64'd1);
        chk("init_addr", 64'(sdram_wr_addr), 64'h123456);
        chk("init_burst", 64'(sdram_wr_burst), 64'd8);
        wr_req[0] = 1'b0;
        wait_idle("t1", 200);

        // T2: W0 and R0 together from a fresh pointer; W0 first.
        do_reset();
        wr_addr[0] = 24'h000100; wr_burst[0] = 10'd8; wr_din[0] = 64'h1111_2222_3333_4444;
        rd_addr[0] = 24'h000200; rd_burst[0] = 10'd8;
        push(4'b0001, 24'h000100, 64'h1111_2222_3333_4444, 8);
        push(4'b0010, 24'h000200, 64'd0, 8);
        wr_req[0] = 1'b1; rd_req[0] = 1'b1;
        wait_drain("t2", 300);
        wr_req = 2'b00; rd_req = 2'b00;
        wait_idle("t2", 200);

        // T3: all four continuous, burst 4: W0,R0,W1,R1,W0.
        do_reset();
        wr_addr[0] = 24'h00A000; wr_burst[0] = 10'd4; wr_din[0] = 64'h0000_0000_0000_00A0;
        rd_addr[0] = 24'h00B000; rd_burst[0] = 10'd4;
        wr_addr[1] = 24'h00C000; wr_burst[1] = 10'd4; wr_din[1] = 64'h0000_0000_0000_00C0;
        rd_addr[1] = 24'h00D000; rd_burst[1] = 10'd4;
        push(4'b0001, 24'h00A000, 64'h00A0, 4);
        push(4'b0010, 24'h00B000, 64'd0, 4);
        push(4'b0100, 24'h00C000, 64'h00C0, 4);
        push(4'b1000, 24'h00D000, 64'd0, 4);
        push(4'b0001, 24'h00A000, 64'h00A0, 4);
        wr_req = 2'b11; rd_req = 2'b11;
        wait_drain("t3", 600);
        wr_req = 2'b00; rd_req = 2'b00;
        wait_idle("t3", 200);

        // T4: W1 with burst 0 is never served; pointer now at R0 so R1 then W0.
        wr_burst[1] = 10'd0; wr_burst[0] = 10'd3; rd_burst[1] = 10'd3;
        push(4'b1000, 24'h00D000, 64'd0, 3);
        push(4'b0001, 24'h00A000, 64'h00A0, 3);
        wr_req = 2'b11; rd_req = 2'b10;
        wait_drain("t4", 300);
        wr_req[0] = 1'b0; rd_req = 2'b00;
        wait_idle("t4", 200);
        wr_req[1] = 1'b0;

        // T5: controller silent, TIMEOUT=15: W1 aborts, then R1 is served next.
        ctl_en = 1'b0;
        wr_burst[1] = 10'd5; rd_burst[1] = 10'd5;
        push(4'b0100, 24'h00C000, 64'h00C0, 0);
        push(4'b1000, 24'h00D000, 64'd0, 0);
        wr_req[1] = 1'b1; rd_req[1] = 1'b1;
        cnt = 0;
        while (!sdram_wr_req && cnt < 50) begin
            @(posedge clk); #1;
            cnt++;
        end
        chk("to_req_seen", 64'(sdram_wr_req), 64'd1);
        cnt = 0;
        while (sdram_wr_req && cnt < 100) begin
            cnt++;
            @(posedge clk); #1;
        end
        chk("to_req_cycles", 64'(cnt), 64'd15);
        chk("to_err", 64'(err_timeout), 64'd1);
        wait_drain("t5", 100);
        wr_req = 2'b00; rd_req = 2'b00;
        wait_idle("t5", 200);
        chk("to_err_sticky", 64'(err_timeout), 64'd1);
        ctl_en = 1'b1;

        // T6: reset in the middle of a W0 transfer.
        wr_burst[0] = 10'd8;
        push(4'b0001, 24'h00A000, 64'h00A0, 8);
        wr_req[0] = 1'b1;
        cnt = 0;
        while (!wr_ack[0] && cnt < 50) begin
            @(negedge clk);
            cnt++;
        end
        chk("xfer_seen", 64'(wr_ack[0]), 64'd1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("mid_rst_grant", 64'(grant), 64'd0);
        chk("mid_rst_wr_req", 64'(sdram_wr_req), 64'd0);
        chk("mid_rst_rd_req", 64'(sdram_rd_req), 64'd0);
        chk("mid_rst_err", 64'(err_timeout), 64'd0);
        chk("mid_rst_state", 64'(dut.state_r), 64'(ST_INIT));
        wr_req[0] = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("stray_acks", 64'(stray_cnt), 64'd0);
        chk("sb_leftover", 64'(sb_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
